// File: rtl/vga_text_ram_axi_pkg.sv
// Shared constants and FSM state types for the VGA text RAM AXI4-Lite responder.
// The optional hardware clear is enabled by VRAM_HW_CLEAR_EN.
package vga_text_pkg;

  localparam int NUM_REGS   = 601;
  localparam int CTRL_IDX   = 600;
  localparam int TEXT_WORDS = 600;
  localparam int CLR_CNT_W  = 10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Colour field LSB positions inside the control word.
  localparam int BKG_B = 1;
  localparam int BKG_G = 5;
  localparam int BKG_R = 9;
  localparam int FGD_B = 13;
  localparam int FGD_G = 17;
  localparam int FGD_R = 21;
  localparam int CTRL_FIELD_W = 4;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ACK  = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACK  = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

endpackage

// File: rtl/vga_text_ram_axi_if.sv
// AXI4-Lite bus bundle between the MicroBlaze interconnect (master) and the text RAM (slave).
interface vga_text_ram_axi_if #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 32
);
  logic [C_ADDR_WIDTH-1:0]   AWADDR;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [C_DATA_WIDTH-1:0]   WDATA;
  logic [C_DATA_WIDTH/8-1:0] WSTRB;
  logic                      WVALID;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [C_ADDR_WIDTH-1:0]   ARADDR;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [C_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/vga_text_ram_axi_clear_seq.sv
// Hardware text-clear sequencer: after start, walks addr 0..TEXT_WORDS-1 once, one word per cycle.
// Only instantiated when VRAM_HW_CLEAR_EN is defined.
module vram_clear_seq
  import vga_text_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  output logic                 busy,
  output logic [CLR_CNT_W-1:0] addr
);
  localparam logic [CLR_CNT_W-1:0] LAST = CLR_CNT_W'(TEXT_WORDS - 1);

  logic                 busy_q, busy_d;
  logic [CLR_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (busy_q) begin
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign addr = cnt_q;
endmodule

// File: rtl/vga_text_ram_axi.sv
// AXI4-Lite responder owning the 601-word text/control RAM that color_mapper reads continuously.
// Define VRAM_HW_CLEAR_EN to add the hardware text clear triggered by control-word bit 0.
module vga_text_ram_axi
  import vga_text_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                    Clk,
  input  logic                    Reset,
  vga_text_ram_axi_if.slave       s_axi,
  output logic [C_DATA_WIDTH-1:0] VGA_RAM [NUM_REGS]
);
  localparam int IDX_W = C_ADDR_WIDTH - 2;
  localparam int LANES = C_DATA_WIDTH / 8;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    rvalid_q, rvalid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [C_DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [C_DATA_WIDTH-1:0] mem_d [NUM_REGS];

  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic                    wr_in_range, rd_in_range;
  logic                    wr_commit;
  logic                    w_block;
  logic [C_DATA_WIDTH-1:0] wr_old, wr_merged;
  logic                    unused_addr_bits;

  assign wr_idx      = s_axi.AWADDR[C_ADDR_WIDTH-1:2];
  assign rd_idx      = s_axi.ARADDR[C_ADDR_WIDTH-1:2];
  assign wr_in_range = int'(wr_idx) < NUM_REGS;
  assign rd_in_range = int'(rd_idx) < NUM_REGS;
  assign unused_addr_bits = ^{s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  assign wr_old = wr_in_range ? mem_q[wr_idx] : '0;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign wr_merged[8*gi +: 8] = s_axi.WSTRB[gi] ? s_axi.WDATA[8*gi +: 8] : wr_old[8*gi +: 8];
  end

`ifdef VRAM_HW_CLEAR_EN
  logic                 clr_start, clr_busy;
  logic [CLR_CNT_W-1:0] clr_addr;

  assign clr_start = wr_commit && (wr_idx == IDX_W'(CTRL_IDX)) && s_axi.WSTRB[0] && s_axi.WDATA[0];

  vram_clear_seq u_clear_seq (
    .Clk   (Clk),
    .Reset (Reset),
    .start (clr_start),
    .busy  (clr_busy),
    .addr  (clr_addr)
  );

  assign w_block = clr_busy;
`else
  assign w_block = 1'b0;
`endif

  // Write channel: AW and W are only ever accepted together, one beat in flight.
  always_comb begin
    w_state_d = w_state_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_commit = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axi.AWVALID && s_axi.WVALID && !bvalid_q && !w_block) begin
          w_state_d = W_ACK;
        end
      end
      W_ACK: begin
        wr_commit = wr_in_range;
        bvalid_d  = 1'b1;
        bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (s_axi.BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read capture uses mem_q, so a same-edge write to the same word returns the old value.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi.ARVALID && !rvalid_q) begin
          r_state_d = R_ACK;
        end
      end
      R_ACK: begin
        rdata_d   = rd_in_range ? mem_q[rd_idx] : '0;
        rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        rvalid_d  = 1'b1;
        r_state_d = R_RESP;
      end
      R_RESP: begin
        if (s_axi.RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
`ifdef VRAM_HW_CLEAR_EN
    if (clr_busy) begin
      mem_d[clr_addr] = '0;
    end
`endif
    if (wr_commit) begin
      mem_d[wr_idx] = wr_merged;
`ifdef VRAM_HW_CLEAR_EN
      // Bit 0 of the control word is a self-clearing trigger, never stored.
      if (wr_idx == IDX_W'(CTRL_IDX)) begin
        mem_d[wr_idx][0] = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      mem_q     <= '{default: '0};
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      mem_q     <= mem_d;
    end
  end

  assign s_axi.AWREADY = (w_state_q == W_ACK);
  assign s_axi.WREADY  = (w_state_q == W_ACK);
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = (r_state_q == R_ACK);
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RRESP   = rresp_q;
  assign s_axi.RDATA   = rdata_q;
  assign VGA_RAM       = mem_q;
endmodule

// File: tb/tb_vga_text_ram_axi.sv
// Scoreboard bench for vga_text_ram_axi: tasks push expected B/R beats, monitors pop and compare.
// Honours VRAM_HW_CLEAR_EN for the control-bit-0 and hardware clear cases.
module tb_vga_text_ram_axi;
  import vga_text_pkg::*;

  localparam int LIMIT = 1000;

  logic        clk;
  logic        rst;
  logic [31:0] vga_ram [NUM_REGS];

  int checks = 0;
  int errors = 0;

  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  vga_text_ram_axi_if bus ();

  vga_text_ram_axi dut (
    .Clk     (clk),
    .Reset   (rst),
    .s_axi   (bus),
    .VGA_RAM (vga_ram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // B monitor
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.BVALID && bus.BREADY) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected actual=BVALID required=no_beat");
        end else begin
          e = bq.pop_front();
          $display("B beat bresp=%b expected=%b", bus.BRESP, e);
          chk("b_resp", {30'b0, bus.BRESP}, {30'b0, e});
        end
      end
    end
  end

  // R monitor
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.RVALID && bus.RREADY) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_unexpected actual=RVALID required=no_beat");
        end else begin
          e = rq.pop_front();
          $display("R beat rdata=%h rresp=%b expected=%h/%b", bus.RDATA, bus.RRESP, e[31:0], e[33:32]);
          chk("r_data", bus.RDATA, e[31:0]);
          chk("r_resp", {30'b0, bus.RRESP}, {30'b0, e[33:32]});
        end
      end
    end
  end

  task automatic wait_bq_empty(input string tag);
    int n = 0;
    while (bq.size() != 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (bq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_b_timeout actual_pending=%0d required=0", tag, bq.size());
      bq.delete();
    end
  endtask

  task automatic wait_rq_empty(input string tag);
    int n = 0;
    while (rq.size() != 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_r_timeout actual_pending=%0d required=0", tag, rq.size());
      rq.delete();
    end
  endtask

  // Returns the cycle index (0 = the cycle VALIDs were raised) at which both READYs are seen.
  task automatic wait_wready(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.AWREADY && bus.WREADY) break;
      n++;
      if (n > LIMIT) break;
    end
    if (n > LIMIT) begin
      checks++;
      errors++;
      $display("FAIL w_ready_timeout actual=no_ready required=ready");
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input bit chk_lat);
    int n;
    bq.push_back(er);
    bus.AWADDR  = a;
    bus.WDATA   = d;
    bus.WSTRB   = s;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    wait_wready(n);
    if (chk_lat) chk("w_ready_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      chk("bvalid_latency", {31'b0, bus.BVALID}, 32'd1);
    end
    wait_bq_empty("write");
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] ed, input logic [1:0] er);
    int n = 0;
    rq.push_back({er, ed});
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.ARREADY) break;
      n++;
      if (n > LIMIT) break;
    end
    chk("ar_ready_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    @(negedge clk);
    chk("rvalid_latency", {31'b0, bus.RVALID}, 32'd1);
    wait_rq_empty("read");
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int nz;
    logic [31:0] ctrl;
    logic [31:0] exp_strb;

    rst = 1'b1;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", {30'b0, bus.AWREADY, bus.ARREADY}, 32'd0);
    chk("rst_valid", {30'b0, bus.BVALID, bus.RVALID}, 32'd0);
    chk("rst_rdata", bus.RDATA, 32'd0);
    chk("rst_vram600", vga_ram[600], 32'd0);
    @(posedge clk); #1;
    axi_read(12'h000, 32'h0, RESP_OKAY);
    axi_read(12'h95C, 32'h0, RESP_OKAY);
    axi_read(12'h960, 32'h0, RESP_OKAY);

    // Full write with cycle-exact timing
    bq.push_back(RESP_OKAY);
    bus.AWADDR = 12'h000; bus.WDATA = 32'h0403_0201; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    @(negedge clk);
    chk("w0_c0_ready", {30'b0, bus.AWREADY, bus.WREADY}, 32'd0);
    @(negedge clk);
    chk("w0_c1_ready", {30'b0, bus.AWREADY, bus.WREADY}, 32'd3);
    chk("w0_c1_vram_old", vga_ram[0], 32'd0);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    @(negedge clk);
    chk("w0_c2_bvalid", {31'b0, bus.BVALID}, 32'd1);
    chk("w0_c2_vram", vga_ram[0], 32'h0403_0201);
    wait_bq_empty("w0");
    @(posedge clk); #1;
    axi_read(12'h000, 32'h0403_0201, RESP_OKAY);

    // Byte strobes on the control word
`ifdef VRAM_HW_CLEAR_EN
    exp_strb = 32'h00BB_00DC;
`else
    exp_strb = 32'h00BB_00DD;
`endif
    axi_write(12'h960, 32'hAABB_CCDD, 4'h5, RESP_OKAY, 1'b1);
    chk("strb_vram600", vga_ram[600], exp_strb);
`ifdef VRAM_HW_CLEAR_EN
    repeat (610) @(posedge clk);
    #1;
`endif

    // Out of range
    axi_write(12'h964, 32'h1234_5678, 4'hF, RESP_SLVERR, 1'b1);
    chk("oor_vram600_kept", vga_ram[600], exp_strb);
    axi_read(12'h964, 32'h0, RESP_SLVERR);
    axi_read(12'hFFC, 32'h0, RESP_SLVERR);

    // Back-pressure: AW alone, then W late; then hold BREADY low with a second write pending
    bus.BREADY = 1'b0;
    bq.push_back(RESP_OKAY);
    bus.AWADDR = 12'h004; bus.WDATA = 32'h1122_3344; bus.WSTRB = 4'hF; bus.AWVALID = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("aw_alone_no_ready", {30'b0, bus.AWREADY, bus.WREADY}, 32'd0);
      if (c == 4) begin
        @(posedge clk); #1;
        bus.WVALID = 1'b1;
      end
    end
    @(negedge clk);
    chk("late_w_ready_c6", {30'b0, bus.AWREADY, bus.WREADY}, 32'd3);
    @(posedge clk); #1;
    bq.push_back(RESP_OKAY);
    bus.AWADDR = 12'h008; bus.WDATA = 32'h5566_7788;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("b_held", {29'b0, bus.BVALID, bus.BRESP}, 32'h4);
      chk("second_not_accepted", {30'b0, bus.AWREADY, bus.WREADY}, 32'd0);
    end
    chk("bp_vram1", vga_ram[1], 32'h1122_3344);
    @(posedge clk); #1;
    bus.BREADY = 1'b1;
    wait_wready(n);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    wait_bq_empty("bp");
    @(posedge clk); #1;
    chk("bp_vram2", vga_ram[2], 32'h5566_7788);

    // Same-edge read and write to one word: read sees the old value
    fork
      axi_write(12'h004, 32'hDEAD_BEEF, 4'hF, RESP_OKAY, 1'b1);
      axi_read(12'h004, 32'h1122_3344, RESP_OKAY);
    join
    axi_read(12'h004, 32'hDEAD_BEEF, RESP_OKAY);

    // WSTRB = 0 completes OKAY with no change
    axi_write(12'h008, 32'hFFFF_FFFF, 4'h0, RESP_OKAY, 1'b1);
    chk("strb0_vram2", vga_ram[2], 32'h5566_7788);

    // Colour fields in the control word
    ctrl = (32'd1 << BKG_B) | (32'd2 << BKG_G) | (32'd3 << BKG_R) |
           (32'd4 << FGD_B) | (32'd5 << FGD_G) | (32'd6 << FGD_R);
    axi_write(12'h960, ctrl, 4'hF, RESP_OKAY, 1'b1);
    chk("ctrl_fgd_r", (vga_ram[600] >> FGD_R) & ((32'd1 << CTRL_FIELD_W) - 1), 32'd6);
    axi_read(12'h960, 32'h00CA_8642, RESP_OKAY);

`ifdef VRAM_HW_CLEAR_EN
    // Hardware clear
    for (int i = 0; i < TEXT_WORDS; i++) axi_write(12'(i * 4), 32'hFFFF_FFFF, 4'hF, RESP_OKAY, 1'b0);
    chk("fill_vram599", vga_ram[599], 32'hFFFF_FFFF);
    axi_write(12'h960, 32'h0000_0001, 4'hF, RESP_OKAY, 1'b1);
    bq.push_back(RESP_OKAY);
    bus.AWADDR = 12'h004; bus.WDATA = 32'h0000_00AA; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    wait_wready(n);
    chk("clear_block_window", {31'b0, (n >= 597 && n <= 601)}, 32'd1);
    nz = 0;
    for (int i = 0; i < TEXT_WORDS; i++) if (vga_ram[i] != 32'd0) nz++;
    chk("clear_nonzero_words", 32'(nz), 32'd0);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    wait_bq_empty("clr");
    @(posedge clk); #1;
    axi_read(12'h000, 32'h0, RESP_OKAY);
    axi_read(12'h95C, 32'h0, RESP_OKAY);
    axi_read(12'h960, 32'h0, RESP_OKAY);
    axi_read(12'h004, 32'h0000_00AA, RESP_OKAY);
`else
    // Bit 0 of the control word is ordinary storage
    axi_write(12'h960, 32'h0000_0001, 4'hF, RESP_OKAY, 1'b1);
    chk("ctrl_bit0_vram600", vga_ram[600], 32'h0000_0001);
    axi_read(12'h960, 32'h0000_0001, RESP_OKAY);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
